// File: rtl/issue_select.sv
// Oldest-ready issue select for one opcode class, with a registered grant and optional
// non-pipelined unit occupancy. Optional perf counters: define ISSUE_SELECT_PERF_EN.
module issue_select #(
    parameter int unsigned ENTRIES      = 16,
    parameter int unsigned AGE_WIDTH    = 5,
    parameter int unsigned OPCODE_WIDTH = 7,
    parameter logic [OPCODE_WIDTH-1:0] OP = 7'b0110011,
    parameter bit          MULTI_CYCLE  = 1'b0,
    parameter int unsigned FU_LATENCY   = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [ENTRIES*OPCODE_WIDTH-1:0]   op,
    input  logic [ENTRIES-1:0]                req,
    input  logic [ENTRIES*AGE_WIDTH-1:0]      age,
    input  logic                              flush,
    input  logic                              fu_ready,
    output logic                              grant_valid,
    output logic [$clog2(ENTRIES)-1:0]        grant_addr,
    output logic [AGE_WIDTH-1:0]              grant_age,
    output logic                              fu_busy
`ifdef ISSUE_SELECT_PERF_EN
    ,
    output logic [31:0]                       perf_issue_cnt,
    output logic [31:0]                       perf_stall_cnt
`endif
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned NODES = 2 * ENTRIES - 1;
    localparam int unsigned CNT_W = 4;

    logic                 fire;
    logic                 load;
    logic [ENTRIES-1:0]   cand;
    logic [CNT_W-1:0]     busy_cnt;
    logic [CNT_W-1:0]     busy_nxt;

    logic                 node_v   [NODES];
    logic [IDX_W-1:0]     node_idx [NODES];
    logic [AGE_WIDTH-1:0] node_age [NODES];

    assign fire = grant_valid & fu_ready;

    // A non-pipelined unit never reloads on its fire cycle; it goes busy first.
    assign load = !flush && (busy_cnt == '0) && (!grant_valid || (fire && !MULTI_CYCLE));

    // The entry being issued this cycle must not be granted again.
    always_comb begin
        cand = '0;
        for (int i = 0; i < int'(ENTRIES); i++) begin
            cand[i] = req[i] && (op[i*OPCODE_WIDTH +: OPCODE_WIDTH] == OP)
                      && !(fire && (grant_addr == IDX_W'(i)));
        end
    end

    // Heap-ordered compare tree: leaves at ENTRIES-1.., left subtree holds lower indices.
    for (genvar g = 0; g < int'(ENTRIES); g++) begin : g_leaf
        assign node_v[ENTRIES-1+g]   = cand[g];
        assign node_idx[ENTRIES-1+g] = IDX_W'(g);
        assign node_age[ENTRIES-1+g] = age[g*AGE_WIDTH +: AGE_WIDTH];
    end

    for (genvar g = 0; g < int'(ENTRIES) - 1; g++) begin : g_node
        logic pick_left;
        assign pick_left = node_v[2*g+1] &&
                           (!node_v[2*g+2] || (node_age[2*g+1] <= node_age[2*g+2]));
        assign node_v[g]   = node_v[2*g+1] | node_v[2*g+2];
        assign node_idx[g] = pick_left ? node_idx[2*g+1] : node_idx[2*g+2];
        assign node_age[g] = pick_left ? node_age[2*g+1] : node_age[2*g+2];
    end

    always_comb begin
        busy_nxt = busy_cnt;
        if (flush)
            busy_nxt = '0;
        else if (MULTI_CYCLE && fire)
            busy_nxt = CNT_W'(FU_LATENCY - 1);
        else if (busy_cnt != '0)
            busy_nxt = busy_cnt - CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_valid <= 1'b0;
            grant_addr  <= '0;
            grant_age   <= '0;
            busy_cnt    <= '0;
            fu_busy     <= 1'b0;
        end else begin
            busy_cnt <= busy_nxt;
            fu_busy  <= (busy_nxt != '0);
            if (flush) begin
                grant_valid <= 1'b0;
            end else if (load) begin
                grant_valid <= node_v[0];
                if (node_v[0]) begin
                    grant_addr <= node_idx[0];
                    grant_age  <= node_age[0];
                end
            end else if (fire) begin
                grant_valid <= 1'b0;
            end
        end
    end

`ifdef ISSUE_SELECT_PERF_EN
    // Counters ignore flush and wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_issue_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (fire)
                perf_issue_cnt <= perf_issue_cnt + 32'd1;
            if (grant_valid && !fu_ready)
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule
